// File: rtl/vision_test_if.sv
// Handshake bundle between the eye-chart sequencer and its key/display neighbours.
// The slave side is the sequencer; the master side drives keys and watches the display.
interface vision_test_if;
  logic       start_pulse;
  logic [3:0] dir_pulse;
  logic       show_en;
  logic [1:0] orient;
  logic [3:0] size_level;
  logic [7:0] bcd;
  logic       X_signal;
  logic       busy;
  logic       done;

  modport master (
    output start_pulse, dir_pulse,
    input  show_en, orient, size_level, bcd, X_signal, busy, done
  );

  modport slave (
    input  start_pulse, dir_pulse,
    output show_en, orient, size_level, bcd, X_signal, busy, done
  );
endinterface

// File: rtl/vision_test_ctrl.sv
// Vision test session sequencer: shows a randomly oriented "E" per trial, judges key
// responses with a timeout, walks acuity levels and reports the result as BCD.
module vision_test_ctrl #(
  parameter int NUM_LEVELS  = 14,
  parameter int PASS_MIN    = 3,
  parameter int FAIL_MAX    = 2,
  parameter int TIMEOUT_CYC = 50000000,
  parameter int FB_CYC      = 5000000
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  vision_test_if.slave bus
);

  // One timer serves both the response window and the feedback hold.
  localparam int TMAX = (TIMEOUT_CYC > FB_CYC) ? TIMEOUT_CYC : FB_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = $clog2(PASS_MIN + 1);
  localparam int WW   = $clog2(FAIL_MAX + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHOW     = 3'd1,
    FEEDBACK = 3'd2,
    EVAL     = 3'd3,
    DONE     = 3'd4
  } state_t;

  typedef struct packed {
    state_t          state;
    logic [3:0]      level;
    logic [CW-1:0]   corr;
    logic [WW-1:0]   wrong;
    logic [TW-1:0]   tmr;
    logic            show_en;
    logic [1:0]      orient;
    logic [3:0]      size_level;
    logic [7:0]      bcd;
    logic            x;
    logic            busy;
    logic            done;
  } ctrl_t;

  ctrl_t      r, n;
  logic [7:0] lfsr;
  logic       go_show, go_done, hit;
  logic [3:0] show_lvl;
  logic [1:0] pick;

  function automatic logic [7:0] acuity(input logic [3:0] l);
    return (l < 4'd10) ? {4'd4, l} : {4'd5, l - 4'd10};
  endfunction

  always_comb begin
    n        = r;
    go_show  = 1'b0;
    go_done  = 1'b0;
    show_lvl = r.level;
    // A hit needs exactly one key bit, and it must be the displayed orientation.
    hit      = (bus.dir_pulse == (4'b0001 << r.orient));
    pick     = (lfsr[1:0] == r.orient) ? lfsr[1:0] + 2'd1 : lfsr[1:0];

    if (bus.start_pulse) begin
      go_show  = 1'b1;
      show_lvl = '0;
      n.corr   = '0;
      n.wrong  = '0;
      n.done   = 1'b0;
      n.busy   = 1'b1;
      n.x      = 1'b0;
    end else begin
      case (r.state)
        SHOW: begin
          if (|bus.dir_pulse || r.tmr == TW'(TIMEOUT_CYC - 1)) begin
            n.state   = FEEDBACK;
            n.tmr     = '0;
            n.show_en = 1'b0;
            n.x       = ~hit;
            if (hit) n.corr  = r.corr + 1'b1;
            else     n.wrong = r.wrong + 1'b1;
          end else begin
            n.tmr = r.tmr + 1'b1;
          end
        end
        FEEDBACK: begin
          if (r.tmr == TW'(FB_CYC - 1)) begin
            n.state = EVAL;
            n.x     = 1'b0;
          end else begin
            n.tmr = r.tmr + 1'b1;
          end
        end
        EVAL: begin
          if (r.corr == CW'(PASS_MIN)) begin
            if (r.level == 4'(NUM_LEVELS - 1)) begin
              go_done = 1'b1;
              n.bcd   = acuity(r.level);
            end else begin
              go_show  = 1'b1;
              show_lvl = r.level + 4'd1;
              n.corr   = '0;
              n.wrong  = '0;
            end
          end else if (r.wrong == WW'(FAIL_MAX)) begin
            go_done = 1'b1;
            // Failing the very first level leaves no acuity to report.
            if (r.level != 4'd0) begin
              n.bcd = acuity(r.level - 4'd1);
            end else begin
              n.bcd = 8'h00;
              n.x   = 1'b1;
            end
          end else begin
            go_show = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (go_done) begin
      n.state   = DONE;
      n.busy    = 1'b0;
      n.done    = 1'b1;
      n.show_en = 1'b0;
    end

    if (go_show) begin
      n.state      = SHOW;
      n.level      = show_lvl;
      n.tmr        = '0;
      n.show_en    = 1'b1;
      n.size_level = show_lvl;
      n.bcd        = acuity(show_lvl);
      n.orient     = pick;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r    <= '0;
      lfsr <= 8'hA5;
    end else begin
      r    <= n;
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign bus.show_en    = r.show_en;
  assign bus.orient     = r.orient;
  assign bus.size_level = r.size_level;
  assign bus.bcd        = r.bcd;
  assign bus.X_signal   = r.x;
  assign bus.busy       = r.busy;
  assign bus.done       = r.done;

endmodule

// File: doc/vision_test_ctrl.md
Name: vision_test_ctrl

Overview:
- Sequencer for the eye-chart display: runs one vision test session end to end.
- Picks an "E" orientation per trial and drives the LED-matrix display state with size level and orientation.
- Judges debounced direction-key responses with a timeout and advances or terminates by level.
- Publishes the current or final acuity as BCD for the seg_led digits, plus the X_signal fail flag.

Parameters:
- NUM_LEVELS, 14, number of acuity levels (range 2..14); level 0 = 4.0, level 13 = 5.3
- PASS_MIN, 3, correct answers needed to pass a level
- FAIL_MAX, 2, wrong answers that end the session at the current level
- TIMEOUT_CYC, 50000000, response window in clocks (5 s at 10 MHz); counter width = $clog2(TIMEOUT_CYC+1)
- FB_CYC, 5000000, feedback hold in clocks (0.5 s)

Ports:
- sys_clk  in  1  system clock, 10 MHz
- sys_rst  in  1  reset, synchronous, active-high
- start_pulse  in  1  one-cycle restart pulse from the debouncer
- dir_pulse  in  4  one-cycle key pulses, bit0 up, bit1 right, bit2 down, bit3 left
- show_en  out  1  display optotype
- orient  out  2  0 up, 1 right, 2 down, 3 left
- size_level  out  4  current level index
- bcd  out  8  two BCD digits of the acuity value
- X_signal  out  1  wrong-answer / session-fail indicator
- busy  out  1  session in progress
- done  out  1  session finished, result valid

Behaviour:
- Reset (sampled on the sys_clk edge while sys_rst=1): state IDLE; show_en=0, orient=0, size_level=0, bcd=8'h00, X_signal=0, busy=0, done=0; counters cleared; LFSR=8'hA5.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Free-runs every cycle, including in IDLE.
- States: IDLE, SHOW, FEEDBACK, EVAL, DONE.
- start_pulse in any state: next cycle enters SHOW with level=0, correct_cnt=wrong_cnt=0, done=0, busy=1, X_signal=0. start_pulse beats any dir_pulse in the same cycle.
- SHOW entry:
  - orient latched from lfsr[1:0]; if equal to the previous orient, use +1 mod 4 (never repeats consecutively).
  - Timeout counter cleared; show_en=1; size_level=level; bcd=acuity(level).
- SHOW:
  - Exactly one dir_pulse bit set: correct if its index equals orient, otherwise wrong.
  - More than one bit set: wrong.
  - No key for TIMEOUT_CYC cycles: wrong.
  - A key in the expiry cycle takes precedence over the timeout.
  - On response, next cycle goes to FEEDBACK with show_en=0, X_signal=1 if wrong else 0, and the matching counter incremented.
- FEEDBACK:
  - Holds FB_CYC cycles, then goes to EVAL and clears X_signal.
  - dir_pulse ignored here, and in IDLE, EVAL and DONE.
- EVAL (1 cycle):
  - correct_cnt==PASS_MIN and level==NUM_LEVELS-1: DONE, result=level.
  - correct_cnt==PASS_MIN otherwise: level+1, counters cleared, go to SHOW.
  - wrong_cnt==FAIL_MAX and level>0: DONE, result=level-1.
  - wrong_cnt==FAIL_MAX and level==0: DONE, no result.
  - Otherwise: back to SHOW (new trial, same level).
- DONE:
  - busy=0, done=1, show_en=0.
  - With a result: bcd=acuity(result), X_signal=0.
  - With no result: bcd=8'h00 and X_signal held at 1.
  - Stays in DONE until start_pulse or reset.
- acuity(l): l<10 gives {4'd4, l[3:0]}; l>=10 gives {4'd5, l-10}. Example: l=13 gives 8'h53.
- Latency: start_pulse at cycle t gives show_en=1 at t+1. A key at cycle t gives FEEDBACK outputs at t+1.
- Reset mid-session: everything returns to reset values next edge, no residual counts.

Test Plan (sim params NUM_LEVELS=3, PASS_MIN=3, FAIL_MAX=2, TIMEOUT_CYC=100, FB_CYC=4):
- Reset then start_pulse: all outputs at reset values; one cycle after start, show_en=1, busy=1, bcd=8'h40, size_level=0.
- Answer orient correctly 9 times: bcd steps 8'h40, 8'h41, 8'h42; ends with done=1, bcd=8'h42, X_signal=0; orient never equal on consecutive trials.
- Two wrong keys at level 0: X_signal=1 for 4 cycles after each; then done=1, bcd=8'h00, X_signal stays 1.
- 3 correct at level 0, then no key for 100 cycles twice: each timeout counted wrong; done with bcd=8'h40.
- Two dir bits in one pulse: counted wrong. Key during FEEDBACK: counters unchanged. Key in the timeout-expiry cycle: judged as key.
- start_pulse mid-SHOW at level 1: next cycle level 0, bcd=8'h40, counters zero. sys_rst mid-FEEDBACK: reset values next edge.
